// File: rtl/router_pkg.sv
// Shared types for the N-channel router control FSM.
package router_pkg;

  typedef enum logic [3:0] {
    DECODE_ADDRESS     = 4'd0,
    LOAD_FIRST_DATA    = 4'd1,
    LOAD_DATA          = 4'd2,
    WAIT_TILL_EMPTY    = 4'd3,
    LOAD_PARITY        = 4'd4,
    CHECK_PARITY_ERROR = 4'd5,
    FIFO_FULL_STATE    = 4'd6,
    LOAD_AFTER_FULL    = 4'd7,
    DROP_PACKET        = 4'd8
  } router_state_t;

  localparam int DROP_CNT_W = 16;

endpackage

// File: rtl/router_wait_timer.sv
// Counts cycles spent waiting for an empty destination FIFO.
module router_wait_timer #(
  parameter int WAIT_TIMEOUT = 0
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  output logic timeout
);

  localparam int CW =
    (WAIT_TIMEOUT > 0) ? $clog2(WAIT_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST =
    CW'((WAIT_TIMEOUT > 0) ? WAIT_TIMEOUT - 1 : 0);

  logic [CW-1:0] cnt_q, cnt_d;

  // Held at zero outside the wait state, so every entry starts from 0.
  always_comb begin
    cnt_d = '0;
    if (en) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign timeout = (WAIT_TIMEOUT != 0) && en && (cnt_q == LAST);

endmodule

// File: rtl/router_fsm_nch.sv
// Router control FSM routing each packet to one of NUM_CH channels,
// with address/timeout dropping and a saturating drop counter.
module router_fsm_nch
  import router_pkg::*;
#(
  parameter int NUM_CH       = 3,
  parameter int ADDR_W       = 2,
  parameter int WAIT_TIMEOUT = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  pkt_valid,
  input  logic [ADDR_W-1:0]     data_in,
  input  logic [NUM_CH-1:0]     fifo_full,
  input  logic [NUM_CH-1:0]     fifo_empty,
  input  logic [NUM_CH-1:0]     soft_reset,
  input  logic                  parity_done,
  input  logic                  low_packet_valid,
  output logic                  detect_add,
  output logic                  lfd_state,
  output logic                  ld_state,
  output logic                  laf_state,
  output logic                  full_state,
  output logic                  write_enb_reg,
  output logic                  rst_int_reg,
  output logic                  busy,
  output logic                  drop_state,
  output logic                  timeout_err,
  output logic [ADDR_W-1:0]     dest_addr,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  router_state_t state_q, state_d;
  logic [ADDR_W-1:0] dest_addr_q, dest_addr_d, dest;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic timeout_err_q, timeout_err_d;
  logic sel_empty, sel_full, sel_srst;
  logic addr_ok, in_wte, timeout;

  assign in_wte  = (state_q == WAIT_TILL_EMPTY);
  assign addr_ok = 32'(data_in) < NUM_CH;

  // Out-of-range addresses select nothing.
  always_comb begin
    dest      = (state_q == DECODE_ADDRESS) ? data_in : dest_addr_q;
    sel_empty = 1'b0;
    sel_full  = 1'b0;
    sel_srst  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (dest == ADDR_W'(i)) begin
        sel_empty = fifo_empty[i];
        sel_full  = fifo_full[i];
      end
      if (dest_addr_q == ADDR_W'(i)) sel_srst = soft_reset[i];
    end
  end

  router_wait_timer #(
    .WAIT_TIMEOUT(WAIT_TIMEOUT)
  ) u_timer (
    .clock  (clock),
    .reset  (reset),
    .en     (in_wte),
    .timeout(timeout)
  );

  always_comb begin
    state_d = state_q;
    if (state_q != DECODE_ADDRESS && sel_srst) begin
      state_d = DECODE_ADDRESS;
    end else begin
      unique case (state_q)
        DECODE_ADDRESS:
          if (pkt_valid) begin
            if (!addr_ok)       state_d = DROP_PACKET;
            else if (sel_empty) state_d = LOAD_FIRST_DATA;
            else                state_d = WAIT_TILL_EMPTY;
          end
        LOAD_FIRST_DATA:
          state_d = LOAD_DATA;
        LOAD_DATA:
          if (sel_full)       state_d = FIFO_FULL_STATE;
          else if (!pkt_valid) state_d = LOAD_PARITY;
        WAIT_TILL_EMPTY:
          if (sel_empty)    state_d = LOAD_FIRST_DATA;
          else if (timeout) state_d = DROP_PACKET;
        LOAD_PARITY:
          state_d = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR:
          state_d = sel_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
        FIFO_FULL_STATE:
          if (!sel_full) state_d = LOAD_AFTER_FULL;
        LOAD_AFTER_FULL:
          if (parity_done)           state_d = DECODE_ADDRESS;
          else if (low_packet_valid) state_d = LOAD_PARITY;
          else                       state_d = LOAD_DATA;
        DROP_PACKET:
          if (!pkt_valid) state_d = DECODE_ADDRESS;
        default:
          state_d = DECODE_ADDRESS;
      endcase
    end
  end

  always_comb begin
    dest_addr_d   = dest_addr_q;
    drop_cnt_d    = drop_cnt_q;
    timeout_err_d = 1'b0;
    if (state_q == DECODE_ADDRESS && pkt_valid) dest_addr_d = data_in;
    if (state_d == DROP_PACKET && state_q != DROP_PACKET) begin
      if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 1'b1;
      timeout_err_d = in_wte;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= DECODE_ADDRESS;
      dest_addr_q   <= '0;
      drop_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      dest_addr_q   <= dest_addr_d;
      drop_cnt_q    <= drop_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign detect_add    = (state_q == DECODE_ADDRESS);
  assign lfd_state     = (state_q == LOAD_FIRST_DATA);
  assign ld_state      = (state_q == LOAD_DATA);
  assign laf_state     = (state_q == LOAD_AFTER_FULL);
  assign full_state    = (state_q == FIFO_FULL_STATE);
  assign rst_int_reg   = (state_q == CHECK_PARITY_ERROR);
  assign drop_state    = (state_q == DROP_PACKET);
  assign write_enb_reg = ld_state || laf_state ||
                         (state_q == LOAD_PARITY);
  assign busy          = !(detect_add || ld_state || drop_state);
  assign timeout_err   = timeout_err_q;
  assign dest_addr     = dest_addr_q;
  assign drop_cnt      = drop_cnt_q;

endmodule
